// File: rtl/proc_exec_unit.sv
// Execute stage: register file, ALU and a control FSM for MV / MVI / ADD / SUB.
// Define PROC_EXEC_OVF_EN to add the signed-overflow output ovf_flag.
module proc_exec_unit #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  localparam int REG_AW  = $clog2(NUM_REGS)
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [2:0]        instr_op,
  input  logic [REG_AW-1:0] instr_rx,
  input  logic [REG_AW-1:0] instr_ry,
  input  logic [DATA_W-1:0] imm_data,
  output logic              done,
  output logic              err,
  output logic              zero_flag,
  output logic              carry_flag,
`ifdef PROC_EXEC_OVF_EN
  output logic              ovf_flag,
`endif
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_t;

  function automatic logic op_is_legal(input logic [2:0] op);
    case (op)
      OP_MV, OP_MVI, OP_ADD, OP_SUB: op_is_legal = 1'b1;
      default:                       op_is_legal = 1'b0;
    endcase
  endfunction

  function automatic logic op_is_arith(input logic [2:0] op);
    case (op)
      OP_ADD, OP_SUB: op_is_arith = 1'b1;
      default:        op_is_arith = 1'b0;
    endcase
  endfunction

  state_t              state_r, state_nxt_s;
  logic [DATA_W-1:0]   regs_r [NUM_REGS];
  logic [2:0]          ir_op_r;
  logic [REG_AW-1:0]   ir_rx_r, ir_ry_r;
  logic [DATA_W-1:0]   ir_imm_r;
  logic [DATA_W:0]     g_r;
  logic                accept_s;
  logic [DATA_W-1:0]   opa_s, opb_s, wr_data_s;
  logic [DATA_W:0]     alu_s;
  logic                done_r, err_r, zero_r, carry_r;

  assign instr_ready = (state_r == ST_IDLE);
  assign accept_s    = instr_valid & instr_ready;
  assign opa_s       = regs_r[ir_rx_r];
  assign opb_s       = regs_r[ir_ry_r];
  assign dbg_data    = regs_r[dbg_addr];
  assign done        = done_r;
  assign err         = err_r;
  assign zero_flag   = zero_r;
  assign carry_flag  = carry_r;

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (op_is_arith(instr_op)) begin
            state_nxt_s = ST_EXEC;
          end else begin
            state_nxt_s = ST_WB;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_EXEC: state_nxt_s = ST_WB;
      ST_WB:   state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // ALU (carry/borrow lands in bit DATA_W) and write-back data select
  always_comb begin
    alu_s     = '0;
    wr_data_s = '0;
    if (ir_op_r == OP_SUB) begin
      alu_s = {1'b0, opa_s} - {1'b0, opb_s};
    end else begin
      alu_s = {1'b0, opa_s} + {1'b0, opb_s};
    end
    case (ir_op_r)
      OP_MV:   wr_data_s = opb_s;
      OP_MVI:  wr_data_s = ir_imm_r;
      default: wr_data_s = g_r[DATA_W-1:0];
    endcase
  end

  // State register and instruction capture
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_r  <= ST_IDLE;
      ir_op_r  <= 3'b000;
      ir_rx_r  <= '0;
      ir_ry_r  <= '0;
      ir_imm_r <= '0;
    end else begin
      state_r <= state_nxt_s;
      if (accept_s) begin
        ir_op_r  <= instr_op;
        ir_rx_r  <= instr_rx;
        ir_ry_r  <= instr_ry;
        ir_imm_r <= imm_data;
      end
    end
  end

  // Register file write-back
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= '0;
      end
    end else if (state_r == ST_WB && op_is_legal(ir_op_r)) begin
      regs_r[ir_rx_r] <= wr_data_s;
    end
  end

  // Holding register G, done/err pulses and status flags
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      g_r     <= '0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
      zero_r  <= 1'b0;
      carry_r <= 1'b0;
    end else begin
      done_r <= (state_nxt_s == ST_WB);
      err_r  <= accept_s & ~op_is_legal(instr_op);
      if (state_r == ST_EXEC) begin
        g_r <= alu_s;
      end
      if (state_r == ST_WB && op_is_arith(ir_op_r)) begin
        zero_r  <= (g_r[DATA_W-1:0] == '0);
        carry_r <= g_r[DATA_W];
      end
    end
  end

`ifdef PROC_EXEC_OVF_EN
  logic g_ovf_r, ovf_r, ovf_s;
  assign ovf_flag = ovf_r;

  // Signed overflow: ADD with like-signed operands, SUB with unlike-signed ones
  always_comb begin
    ovf_s = 1'b0;
    if (ir_op_r == OP_SUB) begin
      ovf_s = (opa_s[DATA_W-1] != opb_s[DATA_W-1]) && (alu_s[DATA_W-1] != opa_s[DATA_W-1]);
    end else begin
      ovf_s = (opa_s[DATA_W-1] == opb_s[DATA_W-1]) && (alu_s[DATA_W-1] != opa_s[DATA_W-1]);
    end
  end

  // Overflow captured with G, published at write-back
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      g_ovf_r <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      if (state_r == ST_EXEC) begin
        g_ovf_r <= ovf_s;
      end
      if (state_r == ST_WB && op_is_arith(ir_op_r)) begin
        ovf_r <= g_ovf_r;
      end
    end
  end
`endif

endmodule

// File: tb/tb_proc_exec_unit.sv
// Directed bench for proc_exec_unit (DATA_W=16, NUM_REGS=8).
module tb_proc_exec_unit;
  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [2:0]  instr_op = 3'b000;
  logic [2:0]  instr_rx = 3'd0;
  logic [2:0]  instr_ry = 3'd0;
  logic [15:0] imm_data = 16'h0000;
  logic        done, err, zero_flag, carry_flag;
  logic [2:0]  dbg_addr = 3'd0;
  logic [15:0] dbg_data;
`ifdef PROC_EXEC_OVF_EN
  logic        ovf_flag;
`endif
  int checks = 0;
  int failures = 0;

  proc_exec_unit #(.DATA_W(16), .NUM_REGS(8)) dut (
    .clock(clock), .resetn(resetn), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_rx(instr_rx), .instr_ry(instr_ry), .imm_data(imm_data),
    .done(done), .err(err), .zero_flag(zero_flag), .carry_flag(carry_flag),
`ifdef PROC_EXEC_OVF_EN
    .ovf_flag(ovf_flag),
`endif
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_reg(input logic [2:0] idx, input logic [15:0] exp);
    dbg_addr = idx;
    #1;
    check($sformatf("r%0d", idx), {16'h0000, dbg_data}, {16'h0000, exp});
  endtask

  // Issue one instruction at a falling edge, measure accept->done latency in cycles.
  task automatic run_op(input logic [2:0] op, input logic [2:0] rx, input logic [2:0] ry,
                        input logic [15:0] imm, input int exp_lat, input logic exp_err);
    int lat;
    @(negedge clock);
    check("ready_before_issue", {31'd0, instr_ready}, 32'd1);
    instr_valid = 1'b1; instr_op = op; instr_rx = rx; instr_ry = ry; imm_data = imm;
    @(negedge clock);
    instr_valid = 1'b0;
    lat = 1;
    while (!done && lat < 8) begin
      @(negedge clock);
      lat++;
    end
    check("latency", lat, exp_lat);
    check("err_at_done", {31'd0, err}, {31'd0, exp_err});
    @(negedge clock);
    check("done_one_cycle", {31'd0, done}, 32'd0);
  endtask

  initial begin
    int acc;
    int dn;
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    #1;
    check("reset_ready", {31'd0, instr_ready}, 32'd1);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_err", {31'd0, err}, 32'd0);

    // Reset while a SUB is in EXEC: no done, everything back to zero.
    run_op(3'b001, 3'd1, 3'd0, 16'h0005, 1, 1'b0);
    run_op(3'b001, 3'd2, 3'd0, 16'h0007, 1, 1'b0);
    @(negedge clock);
    instr_valid = 1'b1; instr_op = 3'b011; instr_rx = 3'd1; instr_ry = 3'd2;
    @(negedge clock);
    instr_valid = 1'b0;
    resetn = 1'b0;
    #1;
    check("abort_done", {31'd0, done}, 32'd0);
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    check("abort_done_after", {31'd0, done}, 32'd0);
    for (int i = 0; i < 8; i++) check_reg(i[2:0], 16'h0000);
    check("post_reset_ready", {31'd0, instr_ready}, 32'd1);
    check("post_reset_zero", {31'd0, zero_flag}, 32'd0);
    check("post_reset_carry", {31'd0, carry_flag}, 32'd0);

    // MVI / MV, flags untouched
    run_op(3'b001, 3'd3, 3'd0, 16'h0020, 1, 1'b0);
    run_op(3'b000, 3'd5, 3'd3, 16'h1234, 1, 1'b0);
    check_reg(3'd3, 16'h0020);
    check_reg(3'd5, 16'h0020);
    check("mv_zero", {31'd0, zero_flag}, 32'd0);
    check("mv_carry", {31'd0, carry_flag}, 32'd0);

    // 5 - 7 borrows
    run_op(3'b001, 3'd1, 3'd0, 16'h0005, 1, 1'b0);
    run_op(3'b001, 3'd2, 3'd0, 16'h0007, 1, 1'b0);
    run_op(3'b011, 3'd1, 3'd2, 16'h0000, 2, 1'b0);
    check_reg(3'd1, 16'hFFFE);
    check("sub_carry", {31'd0, carry_flag}, 32'd1);
    check("sub_zero", {31'd0, zero_flag}, 32'd0);
`ifdef PROC_EXEC_OVF_EN
    check("sub_ovf", {31'd0, ovf_flag}, 32'd0);
`endif

    // ADD wrap and SUB rx==ry
    run_op(3'b001, 3'd4, 3'd0, 16'hFFFF, 1, 1'b0);
    run_op(3'b001, 3'd6, 3'd0, 16'h0001, 1, 1'b0);
    run_op(3'b010, 3'd4, 3'd6, 16'h0000, 2, 1'b0);
    check_reg(3'd4, 16'h0000);
    check("add_wrap_zero", {31'd0, zero_flag}, 32'd1);
    check("add_wrap_carry", {31'd0, carry_flag}, 32'd1);
    run_op(3'b001, 3'd7, 3'd0, 16'h0007, 1, 1'b0);
    run_op(3'b011, 3'd7, 3'd7, 16'h0000, 2, 1'b0);
    check_reg(3'd7, 16'h0000);
    check("subself_zero", {31'd0, zero_flag}, 32'd1);
    check("subself_carry", {31'd0, carry_flag}, 32'd0);

    // Illegal opcode: err with done, no write, flags kept
    run_op(3'b110, 3'd3, 3'd5, 16'hBEEF, 1, 1'b1);
    check_reg(3'd3, 16'h0020);
    check("illegal_zero", {31'd0, zero_flag}, 32'd1);
    check("illegal_carry", {31'd0, carry_flag}, 32'd0);

    // MV onto itself
    run_op(3'b000, 3'd2, 3'd2, 16'h0000, 1, 1'b0);
    check_reg(3'd2, 16'h0007);

    // Signed overflow 0x7FFF + 1
    run_op(3'b001, 3'd0, 3'd0, 16'h7FFF, 1, 1'b0);
    run_op(3'b001, 3'd1, 3'd0, 16'h0001, 1, 1'b0);
    run_op(3'b010, 3'd0, 3'd1, 16'h0000, 2, 1'b0);
    check_reg(3'd0, 16'h8000);
    check("ovfadd_zero", {31'd0, zero_flag}, 32'd0);
    check("ovfadd_carry", {31'd0, carry_flag}, 32'd0);
`ifdef PROC_EXEC_OVF_EN
    check("ovfadd_ovf", {31'd0, ovf_flag}, 32'd1);
`endif

    // Continuous valid: ADD r5,r5 (0x20) repeats every 3 cycles
    @(negedge clock);
    instr_valid = 1'b1; instr_op = 3'b010; instr_rx = 3'd5; instr_ry = 3'd5;
    acc = 0; dn = 0;
    for (int i = 0; i < 9; i++) begin
      if (instr_ready) acc++;
      if (done) dn++;
      @(negedge clock);
    end
    instr_valid = 1'b0;
    check("hold_accepts", acc, 3);
    check("hold_dones", dn, 3);
    @(negedge clock);
    check_reg(3'd5, 16'h0100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
